// File: rtl/data_bus_responder.sv
// Data bus slave: byte-enabled data RAM, TX byte FIFO with ready/valid drain,
// and a free-running 64-bit cycle counter behind one MMIO window.
module data_bus_responder #(
  parameter logic [31:0] DATA_BASE    = 32'h1001_0000,
  parameter int unsigned DATA_ADDR_W  = 10,
  parameter logic [31:0] MMIO_BASE    = 32'hFF20_0000,
  parameter int unsigned FIFO_DEPTH_W = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oError,
  output logic [7:0]  oTxData,
  output logic        oTxValid,
  input  logic        iTxReady
);

  localparam int unsigned RAM_WORDS  = 1 << DATA_ADDR_W;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_W;

  localparam logic [2:0] OFF_TXDATA   = 3'd0;
  localparam logic [2:0] OFF_TXSTATUS = 3'd1;
  localparam logic [2:0] OFF_CYC_LO   = 3'd2;
  localparam logic [2:0] OFF_CYC_HI   = 3'd3;
  localparam logic [2:0] OFF_CYC_CTRL = 3'd4;

  logic [31:0] ram [0:RAM_WORDS-1];
  logic [7:0]  fifo_mem [0:FIFO_DEPTH-1];

  logic                    ram_hit;
  logic                    mmio_hit;
  logic                    unmapped;
  logic [DATA_ADDR_W-1:0]  word_idx;
  logic [2:0]              reg_off;
  logic                    addr_lsb_unused;

  logic [FIFO_DEPTH_W-1:0] rd_ptr;
  logic [FIFO_DEPTH_W-1:0] wr_ptr;
  logic [FIFO_DEPTH_W:0]   count;
  logic                    overflow;
  logic                    fifo_full;
  logic                    push_req;
  logic                    push;
  logic                    pop;
  logic                    ovf_clear;
  logic                    ovf_set;

  logic [63:0]             cycle;
  logic [31:0]             hi_shadow;
  logic                    cyc_clear;
  logic                    lo_read;

  logic [5:0]              status_count;
  logic [31:0]             rd_word;

  assign ram_hit         = (iAddress[31:DATA_ADDR_W+2] == DATA_BASE[31:DATA_ADDR_W+2]);
  assign mmio_hit        = (iAddress[31:5] == MMIO_BASE[31:5]);
  assign unmapped        = !ram_hit && !mmio_hit;
  assign word_idx        = iAddress[DATA_ADDR_W+1:2];
  assign reg_off         = iAddress[4:2];
  assign addr_lsb_unused = ^iAddress[1:0];

  // Count never exceeds the depth, so its top bit alone marks a full FIFO.
  assign fifo_full = count[FIFO_DEPTH_W];
  assign pop       = (count != '0) && iTxReady;
  assign push_req  = iWriteEnable && mmio_hit && (reg_off == OFF_TXDATA) && iByteEnable[0];
  assign push      = push_req && (!fifo_full || pop);
  assign ovf_set   = push_req && fifo_full && !pop;
  assign ovf_clear = iWriteEnable && mmio_hit && (reg_off == OFF_TXSTATUS) &&
                     iByteEnable[0] && iWriteData[7];
  assign cyc_clear = iWriteEnable && mmio_hit && (reg_off == OFF_CYC_CTRL) &&
                     iByteEnable[0] && iWriteData[0];
  assign lo_read   = iReadEnable && mmio_hit && (reg_off == OFF_CYC_LO);

  assign oTxValid     = (count != '0);
  assign oTxData      = fifo_mem[rd_ptr];
  assign status_count = 6'(count);

  // Read data selection for the addressed word (pre-write contents).
  always_comb begin
    rd_word = '0;
    if (ram_hit) begin
      rd_word = ram[word_idx];
    end else if (mmio_hit) begin
      case (reg_off)
        OFF_TXSTATUS: rd_word = {24'b0, overflow, status_count, (count == '0)};
        OFF_CYC_LO:   rd_word = cycle[31:0];
        OFF_CYC_HI:   rd_word = hi_shadow;
        default:      rd_word = '0;
      endcase
    end
  end

  // Registered read data and one-cycle unmapped-access error pulse.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oReadData <= '0;
      oError    <= 1'b0;
    end else begin
      oError <= (iReadEnable || iWriteEnable) && unmapped;
      if (iReadEnable) begin
        oReadData <= rd_word;
      end
    end
  end

  // Byte-lane RAM writes; contents survive reset.
  always_ff @(posedge iCLK) begin
    if (iWriteEnable && ram_hit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (iByteEnable[i]) begin
          ram[word_idx][8*i +: 8] <= iWriteData[8*i +: 8];
        end
      end
    end
  end

  // FIFO storage; on a full push+pop the write slot is the departing head.
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= iWriteData[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_W'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_W'(1);
      if (push && !pop)      count <= count + (FIFO_DEPTH_W+1)'(1);
      else if (pop && !push) count <= count - (FIFO_DEPTH_W+1)'(1);
      if (ovf_clear) overflow <= 1'b0;
      if (ovf_set)   overflow <= 1'b1;
    end
  end

  // Free-running cycle counter with clear, and HI shadow latched on LO read.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cycle     <= '0;
      hi_shadow <= '0;
    end else begin
      if (cyc_clear) cycle <= '0;
      else           cycle <= cycle + 64'd1;
      if (lo_read)   hi_shadow <= cycle[63:32];
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: driver updates a behavioural model
// and queues expected bus responses; a negedge monitor pops and compares.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [3:0]  be;
  logic [31:0] addr, wd;
  logic [31:0] rdata;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          err;
  } resp_t;

  // Behavioural model state
  logic [31:0] mem_m [0:1023];
  logic [7:0]  txq [$];
  bit          ovf_m;
  logic [63:0] cnt_m;
  logic [31:0] hi_m;
  resp_t       resp_q [$];

  always #5 clk = ~clk;

  data_bus_responder #(
    .DATA_BASE   (32'h1001_0000),
    .DATA_ADDR_W (10),
    .MMIO_BASE   (32'hFF20_0000),
    .FIFO_DEPTH_W(3)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iReadEnable (re),
    .iWriteEnable(we),
    .iByteEnable (be),
    .iAddress    (addr),
    .iWriteData  (wd),
    .oReadData   (rdata),
    .oError      (err),
    .oTxData     (tx_data),
    .oTxValid    (tx_valid),
    .iTxReady    (tx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: expectation from pre-edge model, model advanced at the edge.
  task automatic step();
    bit          ram, mmio, unm, push_req, pop, acc;
    int unsigned idx;
    logic [2:0]  off;
    logic [31:0] rv;
    ram  = (addr[31:12] == 20'h10010);
    mmio = (addr[31:5] == 27'(32'hFF20_0000 >> 5));
    unm  = !ram && !mmio;
    idx  = 32'(addr[11:2]);
    off  = addr[4:2];
    rv   = 32'd0;
    if (ram) rv = mem_m[idx];
    else if (mmio) begin
      case (off)
        3'd1: rv = 32'(ovf_m) * 32'd128 + 32'(txq.size()) * 32'd2 +
                   ((txq.size() == 0) ? 32'd1 : 32'd0);
        3'd2: rv = cnt_m[31:0];
        3'd3: rv = hi_m;
        default: rv = 32'd0;
      endcase
    end
    @(posedge clk);
    pop      = tx_ready && (txq.size() > 0);
    push_req = we && mmio && (off == 3'd0) && be[0];
    acc      = push_req && ((txq.size() < 8) || pop);
    if (pop) void'(txq.pop_front());
    if (acc) txq.push_back(wd[7:0]);
    if (push_req && !acc) ovf_m = 1'b1;
    if (we && mmio && off == 3'd1 && be[0] && wd[7]) ovf_m = 1'b0;
    if (re && mmio && off == 3'd2) hi_m = cnt_m[63:32];
    if (we && mmio && off == 3'd4 && be[0] && wd[0]) cnt_m = 64'd0;
    else cnt_m = cnt_m + 64'd1;
    if (we && ram) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
    end
    if (re || we) resp_q.push_back('{is_rd: re, data: rv, err: unm});
    #1;
  endtask

  task automatic bus(input bit r, input bit w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d);
    re = r; we = w; be = b; addr = a; wd = d;
    step();
    re = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    re = 1'b0; we = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    re = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    txq.delete();
    resp_q.delete();
    ovf_m = 1'b0;
    cnt_m = 64'd0;
    hi_m  = 32'd0;
    rst = 1'b0;
  endtask

  // Monitor: compares outputs each negedge against model and queued responses.
  always @(negedge clk) begin : monitor
    resp_t r;
    if (!rst) begin
      check("tx_valid", 32'(tx_valid), (txq.size() != 0) ? 32'd1 : 32'd0);
      if (tx_valid && tx_ready && txq.size() > 0)
        check("tx_data", 32'(tx_data), 32'(txq[0]));
      if (resp_q.size() > 0) begin
        r = resp_q.pop_front();
        check("error", 32'(err), 32'(r.err));
        if (r.is_rd) check("rdata", rdata, r.data);
      end else begin
        check("error_idle", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; be = 4'h0;
    addr = 32'h0; wd = 32'h0; tx_ready = 1'b0;
    ovf_m = 1'b0; cnt_m = 64'd0; hi_m = 32'd0;
    do_reset();

    idle(3);
    check("rst_rdata", rdata, 32'd0);
    bus(1, 0, 4'h0, 32'hFF20_0008, 32'h0);

    for (int i = 0; i < 8; i++)
      bus(0, 1, 4'hF, 32'h1001_0000 + 32'(i * 4), 32'h0);

    bus(0, 1, 4'hF, 32'h1001_0004, 32'hAABB_CCDD);
    bus(0, 1, 4'h1, 32'h1001_0004, 32'h0000_0011);
    bus(1, 0, 4'h0, 32'h1001_0004, 32'h0);
    idle(1);
    check("byte_merge", rdata, 32'hAABB_CC11);

    bus(1, 1, 4'hF, 32'h1001_0008, 32'h1234_5678);
    bus(1, 0, 4'h0, 32'h1001_0008, 32'h0);

    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      bus(0, 1, 4'h1, 32'hFF20_0000, 32'h41 + 32'(i));
    bus(1, 0, 4'h0, 32'hFF20_0004, 32'h0);
    idle(1);
    check("status_ovf", rdata, 32'h90);
    check("head_byte", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    idle(9);
    tx_ready = 1'b0;
    bus(0, 1, 4'hF, 32'hFF20_0004, 32'h80);
    bus(1, 0, 4'h0, 32'hFF20_0004, 32'h0);
    idle(1);
    check("status_clear", rdata, 32'h01);

    for (int i = 0; i < 8; i++)
      bus(0, 1, 4'h1, 32'hFF20_0000, 32'h30 + 32'(i));
    tx_ready = 1'b1;
    bus(0, 1, 4'h1, 32'hFF20_0000, 32'h5A);
    tx_ready = 1'b0;
    bus(1, 0, 4'h0, 32'hFF20_0004, 32'h0);
    idle(1);
    check("full_push_pop", rdata, 32'h10);
    tx_ready = 1'b1;
    idle(9);
    tx_ready = 1'b0;

    bus(1, 0, 4'h0, 32'h0000_1000, 32'h0);
    idle(1);
    bus(0, 1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
    idle(1);

    bus(0, 1, 4'h1, 32'hFF20_0010, 32'h1);
    bus(1, 0, 4'h0, 32'hFF20_0008, 32'h0);
    bus(1, 0, 4'h0, 32'hFF20_000C, 32'h0);
    bus(1, 0, 4'h0, 32'hFF20_0014, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 2))
        0: a = 32'h1001_0000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
        1: a = 32'hFF20_0000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
        default: a = 32'h2000_0000 | $urandom_range(0, 32'hFFFF);
      endcase
      tx_ready = 1'($urandom);
      bus(1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
    end

    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      bus(0, 1, 4'h1, 32'hFF20_0000, 32'h60 + 32'(i));
    bus(1, 0, 4'h0, 32'h1001_0004, 32'h0);
    tx_ready = 1'b1;
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_error", 32'(err), 32'd0);
    tx_ready = 1'b0;
    do_reset();
    idle(3);
    check("resp_drained", 32'(resp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Slave end of the processor data bus: answers read/write requests carrying a read enable, a write enable, a 4-bit byte enable, a 32-bit address and 32-bit write data.
- Integrates three regions behind one bus port:
  - byte-enabled data RAM;
  - transmit byte FIFO with a ready/valid drain port for a serial/console consumer;
  - free-running 64-bit cycle counter.
- Sits between the CPU datapath bus outputs and the peripheral side; returns registered read data.

Parameters:
- DATA_BASE, 32'h1001_0000, byte base address of data RAM
- DATA_ADDR_W, 10, log2 of RAM depth in 32-bit words (1024 words)
- MMIO_BASE, 32'hFF20_0000, byte base address of the 32-byte MMIO window
- FIFO_DEPTH_W, 3, log2 of TX FIFO depth (8 entries)

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iReadEnable  in  1  bus read request
- iWriteEnable  in  1  bus write request
- iByteEnable  in  4  byte lanes for writes; bit i covers iWriteData[8i+7:8i]
- iAddress  in  32  byte address
- iWriteData  in  32  write data, already lane-aligned
- oReadData  out  32  registered read data
- oError  out  1  one-cycle pulse on an access to an unmapped address
- oTxData  out  8  FIFO head byte
- oTxValid  out  1  FIFO not empty
- iTxReady  in  1  consumer accepts oTxData this cycle

Behaviour:

Reset
- Asynchronous. Sets oReadData=0, oError=0, FIFO empty (rd/wr pointers and count = 0), overflow flag=0, cycle counter=0, HI shadow=0.
- RAM contents are not cleared.
- Reset mid-transfer discards pending read data and all queued bytes.

Address decode
- RAM hit: iAddress[31:DATA_ADDR_W+2] == DATA_BASE[31:DATA_ADDR_W+2]. Word index = iAddress[DATA_ADDR_W+1:2].
- MMIO hit: iAddress[31:5] == MMIO_BASE[31:5]. Register offset = iAddress[4:2]; iAddress[1:0] ignored.
- Otherwise unmapped.

Read timing
- On a posedge with iReadEnable=1, oReadData loads the addressed word. It is valid from the next cycle and held until the next read.
- Unmapped read: oReadData loads 0 and oError pulses.

Write timing
- On a posedge with iWriteEnable=1, each byte lane with iByteEnable[i]=1 is written. iByteEnable=0000 writes nothing.
- Unmapped write: ignored, oError pulses.

Read and write in the same cycle
- Write is performed; the read returns pre-write (old) data.

MMIO map (offsets)
- 0x00 TXDATA
  - Write with iByteEnable[0]=1 pushes iWriteData[7:0].
  - Read returns 0.
- 0x04 TXSTATUS
  - Read returns {24'b0, overflow, count[FIFO_DEPTH_W:0] zero-extended to 6 bits, empty}. Bit0 = empty, bits6:1 = count, bit7 = overflow.
  - Writing 1 to bit7 clears overflow.
- 0x08 CYCLE_LO
  - Read returns counter[31:0] and latches counter[63:32] into the HI shadow in the same edge.
- 0x0C CYCLE_HI
  - Read returns the HI shadow.
- 0x10 CYCLE_CTRL
  - Write with bit0=1 clears the counter to 0 on that edge; increments resume next cycle.
- Offsets 0x14–0x1C: reserved; read 0, writes ignored, no oError.

Cycle counter
- +1 every cycle; 64-bit wrap to 0 with no flag.
- A clear overrides the increment.

TX FIFO
- Circular buffer of 2^FIFO_DEPTH_W bytes; count width FIFO_DEPTH_W+1.
- oTxValid = (count != 0). oTxData = head byte, combinational from storage.
- Pop when oTxValid && iTxReady.
- Push is accepted when count < depth, or when count == depth and a pop occurs in the same cycle.
  - Push and pop together leaves count unchanged.
  - Push to a full FIFO with no pop: byte dropped, overflow set (sticky).
- Pointers wrap modulo depth.
- iTxReady while empty: no effect.

Test Plan:
- Reset, then idle 3 cycles -> oReadData=0, oTxValid=0, oError=0. Read 0xFF200008 returns 3 (±1 per the documented edge).
- Write 0x1001_0004 data 0xAABBCCDD BE=1111, then write data 0x00000011 BE=0001, then read 0x1001_0004 -> next cycle oReadData=0xAABBCC11.
- Same-cycle write 0x12345678 and read to 0x1001_0008 previously holding 0x0 -> oReadData=0x0. Subsequent read -> 0x12345678.
- With iTxReady=0, push bytes 0x41..0x49 (9 writes) -> TXSTATUS=0x90 (overflow=1, count=8, empty=0), oTxData=0x41. Raise iTxReady -> 0x41..0x48 drained in order, one per cycle, then oTxValid=0. Write 0x80 to TXSTATUS -> reads 0x01.
- FIFO full, iTxReady=1, push 0x5A in the same cycle -> accepted, count stays 8, 0x5A appears last.
- Read 0x0000_1000 -> oReadData=0, oError high exactly one cycle. Write it -> oError pulse, no RAM or FIFO change. Assert iRST mid-drain -> oTxValid=0 immediately (async).
